mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory-access pipeline stage between execute and writeback. Accepts one load/store
//  request at a time, range-checks it against the data-RAM window, and drives the
//  data_memory port (data_address/write_data/write_enable/read_data). Returns exactly
//  one response per request to writeback, flagging out-of-window accesses as faults.
// PARAMETERS
//  ADDR_W     8    address width
//  DATA_W     8    data width
//  BASE_ADDR  64   first valid data-RAM address
//  DEPTH      64   number of valid lines; last valid = BASE_ADDR+DEPTH-1 (127)
//  READ_LAT   1    cycles from mem_addr valid to mem_rdata capture; legal 1..3
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  reset        in   1       asynchronous, active-high reset
//  req_valid    in   1       execute presents a request
//  req_ready    out  1       stage can accept (high only in IDLE)
//  req_is_store in   1       1=store, 0=load
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   DATA_W  store data
//  req_rd       in   3       destination register tag, passed through
//  mem_addr     out  ADDR_W  to data_memory.data_address
//  mem_wdata    out  DATA_W  to data_memory.write_data
//  mem_we       out  1       to data_memory.write_enable
//  mem_rdata    in   DATA_W  from data_memory.read_data
//  resp_valid   out  1       response to writeback
//  resp_ready   in   1       writeback accepts response
//  resp_data    out  DATA_W  load data (0 for stores and faults)
//  resp_rd      out  3       tag of the completed request
//  resp_is_load out  1       1 = writeback writes register
//  resp_fault   out  1       address outside [BASE_ADDR, BASE_ADDR+DEPTH-1]
//  fault_count  out  8       saturating count of faults since reset
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, all outputs 0, except req_ready=1 once
//    reset deasserts. mem_we falls in the same instant reset rises, even mid-WRITE.
//    An in-flight request is dropped; no response is issued.
//  - FSM: IDLE, READ, WRITE, RESP. Accept = req_valid & req_ready on an edge;
//    request fields are registered and held until the response is accepted.
//  - IDLE->RESP on a faulting access: no memory access, mem_we stays 0,
//    resp_fault=1, resp_data=0. fault_count increments and saturates at 255.
//  - IDLE->WRITE on an in-window store: mem_addr/mem_wdata driven and mem_we=1 for
//    exactly one cycle; then RESP. resp_is_load=0, resp_data=0.
//  - IDLE->READ on an in-window load: mem_addr driven and mem_we=0 for READ_LAT
//    cycles, counted by a latency counter. At the last READ edge mem_rdata is
//    captured into resp_data; then RESP with resp_is_load=1.
//  - Latency, counted from the accept edge (cycle 0) to the first cycle with
//    resp_valid high:
//    - fault: 1 cycle
//    - store: 2 cycles
//    - load: READ_LAT+1 cycles
//  - RESP: resp_valid=1, and all resp_* outputs are held stable until resp_valid &
//    resp_ready on an edge; then IDLE. No new request is accepted in the same edge,
//    so throughput is at most one request per (latency+1) cycles.
//  - mem_we=1 only in WRITE; mem_addr/mem_wdata keep their last value outside
//    READ/WRITE.
//  - Window check is unsigned: addr >= BASE_ADDR and addr <= BASE_ADDR+DEPTH-1.
//    Computation is at ADDR_W+1 bits, so there is no wrap-around at 255.
// TESTING
//  1. RAM[64]=0x01, load addr 64, rd=3, READ_LAT=1 -> resp_valid at cycle 2,
//     resp_data=0x01, resp_rd=3, resp_fault=0.
//  2. Store 0xA5 to addr 100, then load addr 100 -> mem_we high exactly 1 cycle;
//     load returns 0xA5.
//  3. Load addr 63, then store to addr 128 -> both resp_fault=1 at cycle 1;
//     mem_we never high; fault_count=2.
//  4. Load with resp_ready=0 for 5 cycles -> resp_* held constant and req_ready=0
//     throughout; completes on the first cycle resp_ready=1.
//  5. Assert reset during WRITE -> mem_we=0 immediately; no response issued;
//     after release req_ready=1 and fault_count=0.
//  6. 260 faulting loads -> fault_count reads 255 and stays there.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: range-checks one load/store at a time against the
// data-RAM window, drives the data-memory port and returns one response per request.
module mem_access_stage #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BASE_ADDR = 64,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [2:0]        resp_rd,
  output logic              resp_is_load,
  output logic              resp_fault,
  output logic [7:0]        fault_count
);

  localparam int unsigned     LAST_I   = BASE_ADDR + DEPTH - 1;
  localparam logic [ADDR_W:0] LO       = BASE_ADDR[ADDR_W:0];
  localparam logic [ADDR_W:0] HI       = LAST_I[ADDR_W:0];
  localparam logic [1:0]      LAT_LAST = READ_LAT[1:0];

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t          state;
  logic [1:0]      lat_cnt;
  logic [ADDR_W:0] addr_ext;
  logic            in_window;

  // One extra bit so the upper bound never wraps at the top of the address space.
  assign addr_ext  = {1'b0, req_addr};
  assign in_window = (addr_ext >= LO) && (addr_ext <= HI);
  assign req_ready = (state == IDLE) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_rd      <= '0;
      resp_is_load <= 1'b0;
      resp_fault   <= 1'b0;
      fault_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            resp_rd <= req_rd;
            if (!in_window) begin
              state        <= RESP;
              resp_valid   <= 1'b1;
              resp_fault   <= 1'b1;
              resp_is_load <= 1'b0;
              resp_data    <= '0;
              if (fault_count != '1) fault_count <= fault_count + 8'd1;
            end else if (req_is_store) begin
              state        <= WRITE;
              mem_addr     <= req_addr;
              mem_wdata    <= req_wdata;
              mem_we       <= 1'b1;
              resp_fault   <= 1'b0;
              resp_is_load <= 1'b0;
              resp_data    <= '0;
            end else begin
              state        <= READ;
              mem_addr     <= req_addr;
              lat_cnt      <= 2'd1;
              resp_fault   <= 1'b0;
              resp_is_load <= 1'b1;
            end
          end
        end
        WRITE: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        READ: begin
          if (lat_cnt == LAT_LAST) begin
            resp_data  <= mem_rdata;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level reference model plus a per-cycle
// compare process, directed scenarios and a randomized phase.
module tb_mem_access_stage;
  localparam int unsigned READ_LAT = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_is_store;
  logic [7:0] req_addr, req_wdata;
  logic [2:0] req_rd;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
  logic       resp_valid, resp_ready;
  logic [7:0] resp_data;
  logic [2:0] resp_rd;
  logic       resp_is_load, resp_fault;
  logic [7:0] fault_count;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(
    .ADDR_W(8), .DATA_W(8), .BASE_ADDR(64), .DEPTH(64), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_is_load(resp_is_load), .resp_fault(resp_fault),
    .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Data memory device: line i starts as i^0x41, so line 64 holds 0x01.
  logic [7:0] ram [256];
  bit         d_init = 0;
  int         we_pulses = 0;
  assign mem_rdata = ram[mem_addr];

  always @(posedge clk) begin
    if (!d_init) begin
      for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h41;
      d_init = 1;
    end
    if (mem_we === 1'b1) begin
      ram[mem_addr] = mem_wdata;
      we_pulses++;
    end
  end

  // Reference model: one outstanding transaction, latency by request kind.
  logic [7:0] mram [256];
  bit         m_init = 0;
  bit         m_busy = 0;
  int         m_cyc = 0, m_start = 0, m_lat = 0, m_fcnt = 0;
  bit         m_store, m_fault;
  logic [7:0] m_addr, m_wdata, m_data;
  logic [2:0] m_rd;

  always @(posedge clk or posedge reset) begin
    bit was_idle;
    if (!m_init && clk) begin
      for (int i = 0; i < 256; i++) mram[i] = 8'(i) ^ 8'h41;
      m_init = 1;
    end
    if (reset) begin
      m_busy = 0;
      m_fcnt = 0;
    end else begin
      was_idle = !m_busy;
      if (m_busy && m_store && !m_fault && m_cyc == m_start) mram[m_addr] = m_wdata;
      if (m_busy && m_cyc >= m_start + m_lat - 1 && resp_ready) m_busy = 0;
      if (was_idle && req_valid) begin
        m_busy  = 1;
        m_start = m_cyc + 1;
        m_store = req_is_store;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        m_rd    = req_rd;
        m_fault = !(int'(req_addr) >= 64 && int'(req_addr) <= 127);
        m_lat   = m_fault ? 1 : (m_store ? 2 : int'(READ_LAT) + 1);
        m_data  = (m_fault || m_store) ? 8'h00 : mram[req_addr];
        if (m_fault && m_fcnt < 255) m_fcnt++;
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    bit exp_valid;
    if (reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_fault_count", fault_count, 0);
    end else if (m_init) begin
      exp_valid = m_busy && m_cyc >= m_start + m_lat - 1;
      chk("req_ready", req_ready, !m_busy);
      chk("resp_valid", resp_valid, exp_valid);
      chk("mem_we", mem_we, m_busy && m_store && !m_fault && m_cyc == m_start);
      chk("fault_count", fault_count, m_fcnt);
      if (m_busy && !m_fault && m_cyc < m_start + m_lat - 1) chk("mem_addr", mem_addr, m_addr);
      if (m_busy && m_store && !m_fault && m_cyc == m_start) chk("mem_wdata", mem_wdata, m_wdata);
      if (exp_valid) begin
        chk("resp_data", resp_data, m_data);
        chk("resp_rd", resp_rd, m_rd);
        chk("resp_is_load", resp_is_load, !m_store && !m_fault);
        chk("resp_fault", resp_fault, m_fault);
      end
    end
  end

  logic [7:0] r_data;
  logic [2:0] r_rd;
  logic       r_load, r_fault;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and returns at the negedge where resp_valid is first seen.
  task automatic issue(input bit st, input logic [7:0] a, input logic [7:0] d,
                       input logic [2:0] rd, output int lat);
    int guard = 0;
    while (!req_ready && guard < 50) begin step(); guard++; end
    if (guard >= 50) chk("issue_ready_timeout", 0, 1);
    req_valid = 1; req_is_store = st; req_addr = a; req_wdata = d; req_rd = rd;
    step();
    req_valid = 0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    if (!resp_valid) chk("resp_timeout", 0, 1);
    r_data = resp_data; r_rd = resp_rd; r_load = resp_is_load; r_fault = resp_fault;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, w0, guard;
    reset = 1; req_valid = 0; req_is_store = 0; req_addr = '0; req_wdata = '0;
    req_rd = '0; resp_ready = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_fault_count", fault_count, 0);
    chk("reset_resp_valid", resp_valid, 0);

    issue(0, 8'd64, 8'h00, 3'd3, lat);
    chk("t1_lat", lat, 2);
    chk("t1_data", r_data, 8'h01);
    chk("t1_rd", r_rd, 3);
    chk("t1_fault", r_fault, 0);
    chk("t1_is_load", r_load, 1);
    step();

    w0 = we_pulses;
    issue(1, 8'd100, 8'hA5, 3'd5, lat);
    chk("t2_store_lat", lat, 2);
    chk("t2_store_data", r_data, 0);
    chk("t2_store_is_load", r_load, 0);
    step();
    chk("t2_we_pulses", we_pulses - w0, 1);
    issue(0, 8'd100, 8'h00, 3'd6, lat);
    chk("t2_load_lat", lat, 2);
    chk("t2_load_data", r_data, 8'hA5);
    step();

    w0 = we_pulses;
    issue(0, 8'd63, 8'h00, 3'd1, lat);
    chk("t3_load_lat", lat, 1);
    chk("t3_load_fault", r_fault, 1);
    chk("t3_load_data", r_data, 0);
    step();
    issue(1, 8'd128, 8'h33, 3'd2, lat);
    chk("t3_store_lat", lat, 1);
    chk("t3_store_fault", r_fault, 1);
    step();
    chk("t3_we_pulses", we_pulses - w0, 0);
    chk("t3_fault_count", fault_count, 2);

    resp_ready = 0;
    issue(0, 8'd127, 8'h00, 3'd7, lat);
    chk("t4_lat", lat, 2);
    chk("t4_data", r_data, 8'h3E);
    repeat (5) begin
      step();
      chk("t4_hold_valid", resp_valid, 1);
      chk("t4_hold_data", resp_data, r_data);
      chk("t4_hold_rd", resp_rd, r_rd);
      chk("t4_hold_fault", resp_fault, r_fault);
      chk("t4_hold_ready", req_ready, 0);
    end
    resp_ready = 1;
    step();
    chk("t4_done_valid", resp_valid, 0);
    chk("t4_done_ready", req_ready, 1);

    repeat (400) begin
      req_valid    = ($urandom % 10) < 7;
      req_is_store = 1'($urandom);
      case ($urandom % 8)
        0: req_addr = 8'd63;
        1: req_addr = 8'd64;
        2: req_addr = 8'd127;
        3: req_addr = 8'd128;
        4: req_addr = 8'd0;
        5: req_addr = 8'd255;
        default: req_addr = 8'(64 + ($urandom % 8));
      endcase
      req_wdata  = 8'($urandom);
      req_rd     = 3'($urandom);
      resp_ready = ($urandom % 10) < 6;
      step();
    end
    req_valid = 0; resp_ready = 1;
    repeat (10) step();

    guard = 0;
    while (!req_ready && guard < 50) begin step(); guard++; end
    req_valid = 1; req_is_store = 1; req_addr = 8'd100; req_wdata = 8'h5A; req_rd = 3'd4;
    step();
    req_valid = 0;
    chk("t5_we_before_reset", mem_we, 1);
    #1 reset = 1;
    #1;
    chk("t5_we_async_drop", mem_we, 0);
    chk("t5_valid_in_reset", resp_valid, 0);
    chk("t5_ready_in_reset", req_ready, 0);
    step();
    reset = 0;
    #1;
    chk("t5_ready_after", req_ready, 1);
    chk("t5_fault_count", fault_count, 0);
    repeat (4) begin
      step();
      chk("t5_no_resp", resp_valid, 0);
    end

    for (int n = 0; n < 260; n++) begin
      issue(0, (n % 2 == 0) ? 8'd10 : 8'd200, 8'h00, 3'(n), lat);
      step();
    end
    chk("t6_fault_sat", fault_count, 255);
    repeat (2) step();
    chk("t6_fault_sat_hold", fault_count, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
